// File: rtl/axis_pl_frame_dispatcher_pkg.sv
// Shared constants and types for the PL-side frame dispatcher: header layout and FSM states.
package rfsoc_config;

  localparam int DATA_W = 256;

  localparam logic [7:0] HDR_MAGIC     = 8'hA5;
  localparam int         HDR_MAGIC_MSB = 255;
  localparam int         HDR_MAGIC_LSB = 248;
  localparam int         HDR_CH_MSB    = 7;
  localparam int         HDR_CH_LSB    = 0;
  localparam int         HDR_LEN_LSB   = 16;

  typedef enum logic [1:0] {DISP_IDLE, DISP_FWD, DISP_DROP} disp_state_t;

  // Width of a channel select; a single channel still needs one bit.
  function automatic int sel_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/axis_pl_frame_dispatcher_if.sv
// Stream bundle around the dispatcher: the 256-bit input and the shared fan-out bus.
interface axis_pl_frame_dispatcher_if
  import rfsoc_config::*;
#(
  parameter int NUM_CH = 4
) ();
  logic [DATA_W-1:0] s_axis_tdata;
  logic              s_axis_tvalid;
  logic              s_axis_tready;
  logic [DATA_W-1:0] m_axis_tdata;
  logic [NUM_CH-1:0] m_axis_tvalid;
  logic              m_axis_tlast;
  logic [NUM_CH-1:0] m_axis_tready;

  modport slave (
    input  s_axis_tdata, s_axis_tvalid, m_axis_tready,
    output s_axis_tready, m_axis_tdata, m_axis_tvalid, m_axis_tlast
  );

  modport master (
    output s_axis_tdata, s_axis_tvalid, m_axis_tready,
    input  s_axis_tready, m_axis_tdata, m_axis_tvalid, m_axis_tlast
  );
endinterface

// File: rtl/axis_skid_buffer.sv
// Two-entry in-order skid buffer; in_ready depends only on registered occupancy.
module axis_skid_buffer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] in_data_i,
  input  logic         in_valid_i,
  output logic         in_ready_o,
  output logic [W-1:0] out_data_o,
  output logic         out_valid_o,
  input  logic         out_ready_i
);
  logic [W-1:0] head_q, head_d, tail_q, tail_d;
  logic [1:0]   cnt_q, cnt_d;
  logic         push, pop;

  assign in_ready_o  = (cnt_q != 2'd2);
  assign out_valid_o = (cnt_q != 2'd0);
  assign out_data_o  = head_q;
  assign push        = in_valid_i && in_ready_o;
  assign pop         = out_valid_o && out_ready_i;

  always_comb begin
    head_d = head_q;
    tail_d = tail_q;
    cnt_d  = cnt_q;
    case ({push, pop})
      2'b10: begin
        if (cnt_q == 2'd0) head_d = in_data_i;
        else               tail_d = in_data_i;
        cnt_d = cnt_q + 2'd1;
      end
      2'b01: begin
        if (cnt_q == 2'd2) head_d = tail_q;
        cnt_d = cnt_q - 2'd1;
      end
      // push and pop together only happen at occupancy 1
      2'b11: head_d = in_data_i;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head_q <= '0;
      tail_q <= '0;
      cnt_q  <= 2'd0;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
      cnt_q  <= cnt_d;
    end
  end
endmodule

// File: rtl/axis_pl_frame_dispatcher.sv
// Header-driven frame dispatcher: routes payload beats to one of NUM_CH consumers over a shared bus.
module axis_pl_frame_dispatcher
  import rfsoc_config::*;
#(
  parameter int NUM_CH = 4,
  parameter int LEN_W  = 16
) (
  input  logic                        pl_clk,
  input  logic                        rst,
  axis_pl_frame_dispatcher_if.slave   axis,
  output logic                        busy,
  output logic                        frame_done,
  output logic                        hdr_err,
  output logic [15:0]                 frame_cnt,
  output logic [7:0]                  err_cnt
);
  localparam int SEL_W = sel_w(NUM_CH);
  localparam int ENT_W = DATA_W + SEL_W + 1;
  localparam logic [8:0] NUM_CH_L = 9'(NUM_CH);

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [SEL_W-1:0]  sel;
    logic              last;
  } ent_t;

  disp_state_t       state_q, state_d;
  logic [LEN_W-1:0]  rem_q, rem_d;
  logic [SEL_W-1:0]  sel_q, sel_d;
  logic [15:0]       frame_cnt_q;
  logic [7:0]        err_cnt_q;

  logic              magic_ok, ch_ok, s_fire, sk_push, sk_ready, sk_vld, out_ready;
  logic [7:0]        hdr_ch;
  logic [LEN_W-1:0]  hdr_len;
  ent_t              ent_in, ent_out;

  assign magic_ok = (axis.s_axis_tdata[HDR_MAGIC_MSB:HDR_MAGIC_LSB] == HDR_MAGIC);
  assign hdr_ch   = axis.s_axis_tdata[HDR_CH_MSB:HDR_CH_LSB];
  assign hdr_len  = axis.s_axis_tdata[HDR_LEN_LSB +: LEN_W];
  assign ch_ok    = ({1'b0, hdr_ch} < NUM_CH_L);
  assign s_fire   = axis.s_axis_tvalid && axis.s_axis_tready;

  always_ff @(posedge pl_clk) begin
    if (rst) begin
      state_q <= DISP_IDLE;
      rem_q   <= '0;
      sel_q   <= '0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      sel_q   <= sel_d;
    end
  end

  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    sel_d   = sel_q;
    case (state_q)
      DISP_IDLE: begin
        if (s_fire && magic_ok && hdr_len != '0) begin
          rem_d = hdr_len;
          if (ch_ok) begin
            sel_d   = hdr_ch[SEL_W-1:0];
            state_d = DISP_FWD;
          end else begin
            state_d = DISP_DROP;
          end
        end
      end
      DISP_FWD, DISP_DROP: begin
        if (s_fire) begin
          rem_d = rem_q - 1'b1;
          if (rem_q == LEN_W'(1)) state_d = DISP_IDLE;
        end
      end
      default: state_d = DISP_IDLE;
    endcase
  end

  // Header beats are always taken in IDLE; only payload is throttled by the output stage.
  always_comb begin
    axis.s_axis_tready = 1'b0;
    sk_push            = 1'b0;
    hdr_err            = 1'b0;
    if (!rst) begin
      case (state_q)
        DISP_IDLE: begin
          axis.s_axis_tready = 1'b1;
          hdr_err            = axis.s_axis_tvalid && (!magic_ok || !ch_ok);
        end
        DISP_FWD: begin
          axis.s_axis_tready = sk_ready;
          sk_push            = axis.s_axis_tvalid && sk_ready;
        end
        DISP_DROP: axis.s_axis_tready = 1'b1;
        default: ;
      endcase
    end
  end

  assign ent_in = '{data: axis.s_axis_tdata, sel: sel_q, last: (rem_q == LEN_W'(1))};

  axis_skid_buffer #(.W(ENT_W)) u_skid (
    .clk         (pl_clk),
    .rst         (rst),
    .in_data_i   (ent_in),
    .in_valid_i  (sk_push),
    .in_ready_o  (sk_ready),
    .out_data_o  (ent_out),
    .out_valid_o (sk_vld),
    .out_ready_i (out_ready)
  );

  assign out_ready         = axis.m_axis_tready[ent_out.sel];
  assign axis.m_axis_tdata = ent_out.data;
  assign axis.m_axis_tlast = sk_vld && ent_out.last;

  always_comb begin
    axis.m_axis_tvalid = '0;
    if (sk_vld) axis.m_axis_tvalid[ent_out.sel] = 1'b1;
  end

  assign frame_done = sk_vld && out_ready && ent_out.last;
  assign busy       = (state_q != DISP_IDLE) || sk_vld;

  always_ff @(posedge pl_clk) begin
    if (rst) begin
      frame_cnt_q <= '0;
      err_cnt_q   <= '0;
    end else begin
      if (frame_done) frame_cnt_q <= frame_cnt_q + 16'd1;
      if (hdr_err && err_cnt_q != 8'hFF) err_cnt_q <= err_cnt_q + 8'd1;
    end
  end

  assign frame_cnt = frame_cnt_q;
  assign err_cnt   = err_cnt_q;
endmodule

// File: tb/tb_axis_pl_frame_dispatcher.sv
// Directed bench for axis_pl_frame_dispatcher (NUM_CH=4, LEN_W=16).
module tb_axis_pl_frame_dispatcher;
  logic        clk = 1'b0;
  logic        rst;
  logic        busy, frame_done, hdr_err;
  logic [15:0] frame_cnt;
  logic [7:0]  err_cnt;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  axis_pl_frame_dispatcher_if #(.NUM_CH(4)) bus ();

  axis_pl_frame_dispatcher #(.NUM_CH(4), .LEN_W(16)) dut (
    .pl_clk     (clk),
    .rst        (rst),
    .axis       (bus),
    .busy       (busy),
    .frame_done (frame_done),
    .hdr_err    (hdr_err),
    .frame_cnt  (frame_cnt),
    .err_cnt    (err_cnt)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Output-side monitor: records handshakes and counts events sampled mid-cycle.
  logic [255:0] q_data[$];
  logic [3:0]   q_vld[$];
  logic         q_last[$];
  int           q_cyc[$];
  int           done_cnt = 0, herr_cnt = 0, ch0_seen = 0, sready_low = 0, stall_viol = 0;
  logic         prev_stall = 1'b0;
  logic [255:0] prev_data;
  logic [3:0]   prev_vld;
  logic         prev_last;

  always @(negedge clk) begin
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall && (bus.m_axis_tvalid !== prev_vld || bus.m_axis_tdata !== prev_data ||
                         bus.m_axis_tlast !== prev_last)) stall_viol++;
      if (bus.m_axis_tvalid[0]) ch0_seen++;
      if (!bus.s_axis_tready) sready_low++;
      if (frame_done) done_cnt++;
      if (hdr_err) herr_cnt++;
      if (|(bus.m_axis_tvalid & bus.m_axis_tready)) begin
        q_data.push_back(bus.m_axis_tdata);
        q_vld.push_back(bus.m_axis_tvalid);
        q_last.push_back(bus.m_axis_tlast);
        q_cyc.push_back(cyc);
      end
      prev_stall = |bus.m_axis_tvalid && !(|(bus.m_axis_tvalid & bus.m_axis_tready));
      prev_vld   = bus.m_axis_tvalid;
      prev_data  = bus.m_axis_tdata;
      prev_last  = bus.m_axis_tlast;
    end
  end

  initial begin
    #600000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [255:0] hdr(input logic [7:0] magic, input logic [7:0] ch,
                                       input logic [15:0] len);
    logic [255:0] h = '0;
    h[127:64]  = 64'hDEAD_BEEF_0123_4567;
    h[255:248] = magic;
    h[7:0]     = ch;
    h[31:16]   = len;
    return h;
  endfunction

  function automatic logic [255:0] dat(input logic [7:0] id, input int i);
    logic [31:0] w = {id, 16'h5A5A, 8'(i)};
    return {8{w}};
  endfunction

  // Holds one beat until accepted; leaves tvalid high so consecutive calls are gap-free.
  task automatic send(input logic [255:0] d, output int acc_cyc);
    logic acc;
    int   n = 0;
    bus.s_axis_tdata  = d;
    bus.s_axis_tvalid = 1'b1;
    do begin
      @(negedge clk);
      acc     = bus.s_axis_tready;
      acc_cyc = cyc;
      @(posedge clk); #1;
      n++;
    end while (!acc && n < 50);
    if (!acc) chk("send_accept_timeout", 256'(acc), 256'(1));
  endtask

  task automatic idle();
    bus.s_axis_tvalid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    @(negedge clk);
    while (busy && n < 200) begin @(negedge clk); n++; end
    chk("drain_busy", 256'(busy), 256'(0));
    @(posedge clk); #1;
  endtask

  task automatic chk_frame(input string tag, input int base, input int n,
                           input logic [3:0] vld, input logic [7:0] id);
    chk($sformatf("%s_count", tag), 256'(q_data.size() - base), 256'(n));
    for (int i = 0; i < n; i++) begin
      if (base + i < q_data.size()) begin
        chk($sformatf("%s_vld%0d", tag, i),  256'(q_vld[base+i]),  256'(vld));
        chk($sformatf("%s_data%0d", tag, i), q_data[base+i],       dat(id, i));
        chk($sformatf("%s_last%0d", tag, i), 256'(q_last[base+i]), 256'(i == n - 1));
      end
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_m_tvalid"},   256'(bus.m_axis_tvalid), 256'(0));
    chk({tag, "_m_tlast"},    256'(bus.m_axis_tlast),  256'(0));
    chk({tag, "_m_tdata"},    bus.m_axis_tdata,         256'(0));
    chk({tag, "_busy"},       256'(busy),               256'(0));
    chk({tag, "_frame_done"}, 256'(frame_done),         256'(0));
    chk({tag, "_hdr_err"},    256'(hdr_err),            256'(0));
    chk({tag, "_frame_cnt"},  256'(frame_cnt),          256'(0));
    chk({tag, "_err_cnt"},    256'(err_cnt),            256'(0));
  endtask

  initial begin
    int qb, db, hb, sb, cb, a0, tmp;
    rst = 1'b1;
    bus.s_axis_tdata  = '0;
    bus.s_axis_tvalid = 1'b0;
    bus.m_axis_tready = 4'hF;

    // Reset
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_s_tready", 256'(bus.s_axis_tready), 256'(0));
    chk_reset_vals("rst");
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_s_tready", 256'(bus.s_axis_tready), 256'(1));
    @(posedge clk); #1;

    // ch2, L=3: three beats, tlast on last, 1-cycle latency, 1 beat/cycle
    qb = q_data.size(); db = done_cnt;
    send(hdr(8'hA5, 8'd2, 16'd3), tmp);
    send(dat(8'hD0, 0), a0);
    send(dat(8'hD0, 1), tmp);
    send(dat(8'hD0, 2), tmp);
    idle();
    drain();
    chk_frame("f1", qb, 3, 4'b0100, 8'hD0);
    if (q_cyc.size() >= qb + 3) begin
      chk("f1_latency", 256'(q_cyc[qb] - a0), 256'(1));
      chk("f1_gap01",   256'(q_cyc[qb+1] - q_cyc[qb]), 256'(1));
      chk("f1_gap12",   256'(q_cyc[qb+2] - q_cyc[qb+1]), 256'(1));
    end
    chk("f1_done",      256'(done_cnt - db), 256'(1));
    chk("f1_frame_cnt", 256'(frame_cnt),     256'(1));
    chk("f1_err_cnt",   256'(err_cnt),       256'(0));

    // Bad magic rejected, next valid header forwarded
    qb = q_data.size(); hb = herr_cnt;
    send(hdr(8'h5A, 8'd1, 16'd2), tmp);
    send(hdr(8'hA5, 8'd1, 16'd1), tmp);
    send(dat(8'hE0, 0), tmp);
    idle();
    drain();
    chk("bad_magic_herr",    256'(herr_cnt - hb), 256'(1));
    chk("bad_magic_err_cnt", 256'(err_cnt),       256'(1));
    chk_frame("after_bad", qb, 1, 4'b0010, 8'hE0);
    chk("after_bad_frame_cnt", 256'(frame_cnt), 256'(2));

    // ch7 frame drained (its first beat looks like a valid header), then ch0/L=1
    qb = q_data.size(); hb = herr_cnt;
    send(hdr(8'hA5, 8'd7, 16'd2), tmp);
    send(hdr(8'hA5, 8'd0, 16'd1), tmp);
    send(dat(8'hCC, 1), tmp);
    send(hdr(8'hA5, 8'd0, 16'd1), tmp);
    send(dat(8'hF0, 0), tmp);
    idle();
    drain();
    chk("drop_herr",    256'(herr_cnt - hb), 256'(1));
    chk("drop_err_cnt", 256'(err_cnt),       256'(2));
    chk_frame("post_drop", qb, 1, 4'b0001, 8'hF0);

    // ch1/L=4 with ready[1] toggling 1,0,0 and ready[0] high
    qb = q_data.size(); cb = ch0_seen; sb = sready_low;
    fork
      begin
        send(hdr(8'hA5, 8'd1, 16'd4), tmp);
        for (int i = 0; i < 4; i++) send(dat(8'hB0, i), tmp);
        idle();
      end
      begin
        for (int c = 0; c < 30; c++) begin
          bus.m_axis_tready = {2'b11, 1'(c % 3 == 0), 1'b1};
          @(posedge clk); #1;
        end
        bus.m_axis_tready = 4'hF;
      end
    join
    drain();
    chk_frame("bp", qb, 4, 4'b0010, 8'hB0);
    chk("bp_no_ch0",        256'(ch0_seen - cb),     256'(0));
    chk("bp_stall_stable",  256'(stall_viol),        256'(0));
    chk("bp_sready_low",    256'(sready_low > sb),   256'(1));

    // Reset after 2 of 5 beats of a ch3 frame
    send(hdr(8'hA5, 8'd3, 16'd5), tmp);
    send(dat(8'h33, 0), tmp);
    send(dat(8'h33, 1), tmp);
    rst = 1'b1;
    idle();
    @(negedge clk);
    chk("midrst_s_tready", 256'(bus.s_axis_tready), 256'(0));
    @(posedge clk); #1;
    @(negedge clk);
    chk_reset_vals("midrst");
    @(posedge clk); #1;
    rst = 1'b0;
    qb = q_data.size();
    send(hdr(8'hA5, 8'd3, 16'd1), tmp);
    send(dat(8'h3F, 0), tmp);
    idle();
    drain();
    chk_frame("post_rst", qb, 1, 4'b1000, 8'h3F);
    chk("post_rst_frame_cnt", 256'(frame_cnt), 256'(1));

    // Back-to-back ch0/L=1 then ch1/L=1, no input gap; header cycle separates the outputs
    qb = q_data.size(); db = done_cnt;
    send(hdr(8'hA5, 8'd0, 16'd1), tmp);
    send(dat(8'hA0, 0), tmp);
    send(hdr(8'hA5, 8'd1, 16'd1), tmp);
    send(dat(8'hA1, 0), tmp);
    idle();
    drain();
    chk("b2b_count", 256'(q_data.size() - qb), 256'(2));
    if (q_data.size() >= qb + 2) begin
      chk("b2b_vld0",  256'(q_vld[qb]),   256'(4'b0001));
      chk("b2b_data0", q_data[qb],        dat(8'hA0, 0));
      chk("b2b_vld1",  256'(q_vld[qb+1]), 256'(4'b0010));
      chk("b2b_data1", q_data[qb+1],      dat(8'hA1, 0));
      chk("b2b_last",  256'({q_last[qb], q_last[qb+1]}), 256'(2'b11));
      chk("b2b_gap",   256'(q_cyc[qb+1] - q_cyc[qb]), 256'(2));
    end
    chk("b2b_done",      256'(done_cnt - db), 256'(2));
    chk("b2b_frame_cnt", 256'(frame_cnt),     256'(3));

    // Zero-length headers: valid channel is silent, bad channel is an error
    qb = q_data.size(); hb = herr_cnt; db = done_cnt;
    send(hdr(8'hA5, 8'd2, 16'd0), tmp);
    send(hdr(8'hA5, 8'd9, 16'd0), tmp);
    send(hdr(8'hA5, 8'd2, 16'd1), tmp);
    send(dat(8'h77, 0), tmp);
    idle();
    drain();
    chk("len0_herr",      256'(herr_cnt - hb), 256'(1));
    chk("len0_err_cnt",   256'(err_cnt),       256'(1));
    chk("len0_done",      256'(done_cnt - db), 256'(1));
    chk_frame("len0", qb, 1, 4'b0100, 8'h77);
    chk("len0_frame_cnt", 256'(frame_cnt),     256'(4));

    // err_cnt saturation
    hb = herr_cnt;
    for (int i = 0; i < 300; i++) send(hdr(8'h00, 8'd0, 16'd1), tmp);
    idle();
    @(negedge clk);
    chk("sat_herr",      256'(herr_cnt - hb), 256'(300));
    chk("sat_err_cnt",   256'(err_cnt),       256'(255));
    chk("sat_frame_cnt", 256'(frame_cnt),     256'(4));
    chk("sat_busy",      256'(busy),          256'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
